// File: rtl/cronometro_pkg.sv
// Shared stopwatch definitions: FSM state encoding, prescaler width and default rate.
// Also imported by the digit counters and the display mux.
package cronometro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } state_t;

  localparam int PRESCALE_DEF = 500000;
  localparam int PRESC_W      = 24;

  function automatic logic is_counting(input state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/boton_pulso.sv
// Raw button to one-cycle pulse: 2-FF synchronizer, optional debounce, rising-edge detect.
// Debounce counter present only when DEBOUNCE_EN is defined.
module boton_pulso #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sync1, sync2;
  logic level, level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] db_cnt;

  // Saturates at the threshold so a long press yields a single accepted level.
  always_ff @(posedge clk) begin
    if (rst || !sync2) begin
      db_cnt <= '0;
    end else if (db_cnt != CW'(DEBOUNCE_CYCLES)) begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign level = (db_cnt == CW'(DEBOUNCE_CYCLES));
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/control_cronometro.sv
// Stopwatch run/pause/lap/reset controller with centisecond prescaler.
// Build with DEBOUNCE_EN defined to add per-button debounce counters.
module control_cronometro
  import cronometro_pkg::*;
#(
  parameter int PRESCALE        = PRESCALE_DEF,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_stop,
  input  logic       btn_reset,
  input  logic       btn_lap,
  input  logic       max_reached,
  output logic       stay,
  output logic       clr,
  output logic       hold,
  output logic       running,
  output logic [1:0] state
);

  logic               p_start_stop, p_reset, p_lap;
  state_t             st, st_nxt;
  logic [PRESC_W-1:0] presc, presc_nxt;
  logic               tick;
  logic               stay_nxt, clr_nxt, hold_nxt, running_nxt;

  boton_pulso #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bp_start_stop (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_start_stop),
    .pulse (p_start_stop)
  );

  boton_pulso #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bp_reset (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_reset),
    .pulse (p_reset)
  );

  boton_pulso #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bp_lap (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_lap),
    .pulse (p_lap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= ST_IDLE;
      presc   <= '0;
      stay    <= 1'b0;
      clr     <= 1'b0;
      hold    <= 1'b0;
      running <= 1'b0;
    end else begin
      st      <= st_nxt;
      presc   <= presc_nxt;
      stay    <= stay_nxt;
      clr     <= clr_nxt;
      hold    <= hold_nxt;
      running <= running_nxt;
    end
  end

  assign tick = is_counting(st) && (presc == PRESC_W'(PRESCALE - 1));

  // Reset beats saturation, saturation beats the remaining buttons.
  always_comb begin
    st_nxt = st;
    if (p_reset) begin
      st_nxt = ST_IDLE;
    end else if (tick && max_reached) begin
      st_nxt = ST_PAUSE;
    end else begin
      case (st)
        ST_IDLE:  if (p_start_stop) st_nxt = ST_RUN;
        ST_RUN: begin
          if (p_start_stop)  st_nxt = ST_PAUSE;
          else if (p_lap)    st_nxt = ST_LAP;
        end
        ST_LAP: begin
          if (p_start_stop)  st_nxt = ST_PAUSE;
          else if (p_lap)    st_nxt = ST_RUN;
        end
        ST_PAUSE: if (p_start_stop && !max_reached) st_nxt = ST_RUN;
        default:  st_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stay_nxt    = tick && !max_reached && !p_reset;
    clr_nxt     = p_reset;
    hold_nxt    = (st_nxt == ST_LAP);
    running_nxt = is_counting(st_nxt);
    presc_nxt   = presc;
    if (st_nxt == ST_IDLE) begin
      presc_nxt = '0;
    end else if (is_counting(st)) begin
      presc_nxt = tick ? '0 : presc + 1'b1;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_control_cronometro.sv
// Scoreboarded bench: event-level reference model predicts every output cycle.
// Define DEBOUNCE_EN to exercise the debounce build, including glitch rejection.
module tb_control_cronometro;

  localparam int P = 4;
  localparam int D = 3;
`ifdef DEBOUNCE_EN
  localparam int NEED = D;
  localparam int DLY  = 3;
`else
  localparam int NEED = 1;
  localparam int DLY  = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start_stop = 1'b0;
  logic       btn_reset = 1'b0;
  logic       btn_lap = 1'b0;
  logic       max_reached = 1'b0;
  logic       stay, clr, hold, running;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  control_cronometro #(.PRESCALE(P), .DEBOUNCE_CYCLES(D)) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_start_stop (btn_start_stop),
    .btn_reset      (btn_reset),
    .btn_lap        (btn_lap),
    .max_reached    (max_reached),
    .stay           (stay),
    .clr            (clr),
    .hold           (hold),
    .running        (running),
    .state          (state)
  );

  // Reference model: a press is accepted once the raw level has been seen high
  // NEED times in a row; it takes effect DLY edges later. Modes: 0 idle, 1 run,
  // 2 pause, 3 lap. "elapsed" counts cycles spent counting since the last clear.
  int         k = 0;
  int         runlen[3];
  bit [2:0]   sched[int];
  int         mode = 0;
  int         elapsed = 0;

  always @(posedge clk) begin : model
    bit [2:0] raw, ev, m;
    bit       tick, e_stay, e_clr, counting;
    int       nmode;
    raw = {btn_lap, btn_start_stop, btn_reset};
    if (rst) begin
      for (int b = 0; b < 3; b++) runlen[b] = 0;
      sched.delete();
      mode = 0;
      elapsed = 0;
      exp_q.push_back(6'b0);
    end else begin
      for (int b = 0; b < 3; b++) begin
        runlen[b] = raw[b] ? runlen[b] + 1 : 0;
        if (runlen[b] == NEED) begin
          m = sched.exists(k + DLY) ? sched[k + DLY] : 3'b000;
          m[b] = 1'b1;
          sched[k + DLY] = m;
        end
      end
      ev = 3'b000;
      if (sched.exists(k)) begin
        ev = sched[k];
        sched.delete(k);
      end
      counting = (mode == 1) || (mode == 3);
      tick     = counting && ((elapsed + 1) % P == 0);
      nmode    = mode;
      e_clr    = 1'b0;
      if (ev[0]) begin
        nmode = 0;
        e_clr = 1'b1;
      end else if (tick && max_reached) begin
        nmode = 2;
      end else if (ev[1]) begin
        if (mode == 0) nmode = 1;
        else if (mode == 2) nmode = max_reached ? 2 : 1;
        else nmode = 2;
      end else if (ev[2] && counting) begin
        nmode = (mode == 1) ? 3 : 1;
      end
      e_stay = tick && !max_reached && !ev[0];
      if (counting) elapsed++;
      if (nmode == 0) elapsed = 0;
      mode = nmode;
      exp_q.push_back({2'(nmode), e_stay, e_clr, (nmode == 3), (nmode == 1 || nmode == 3)});
    end
    k++;
  end

  always @(negedge clk) begin : monitor
    logic [5:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state, stay, clr, hold, running};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs @%0t: got state=%b stay=%b clr=%b hold=%b running=%b, want state=%b stay=%b clr=%b hold=%b running=%b",
                 $time, a[5:4], a[3], a[2], a[1], a[0], e[5:4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mask bits: [2]=lap, [1]=start_stop, [0]=reset
  task automatic press(input bit [2:0] msk, input int len);
    {btn_lap, btn_start_stop, btn_reset} = msk;
    step(len);
    {btn_lap, btn_start_stop, btn_reset} = 3'b000;
    step(2);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    step(n);
    checks++;
    if ({state, stay, clr, hold, running} !== 6'b0) begin
      errors++;
      $display("FAIL reset state @%0t: got state=%b stay=%b clr=%b hold=%b running=%b",
               $time, state, stay, clr, hold, running);
    end
    rst = 1'b0;
    step(1);
  endtask

  task automatic wait_stay(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      if (stay === 1'b1) seen = 1'b1;
      else step(1);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout @%0t: no stay pulse within %0d cycles", $time, max_cyc);
    end
  endtask

  initial begin : stim
    bit [2:0] msk;
    int       r;
    step(3);
    rst = 1'b0;
    step(2);

    // run for ten ticks, then lap in and out
    press(3'b010, NEED);
    wait_stay(4 * P);
    step(40);
    press(3'b100, NEED);
    step(12);
    press(3'b100, NEED);
    step(6);

    // synchronous reset while running, then restart from a zero fraction
    do_reset(2);
    press(3'b010, NEED);
    step(9);

    // pause with a partial fraction, then resume
    press(3'b010, NEED);
    step(20);
    press(3'b010, NEED);
    wait_stay(4 * P);
    step(10);

    // all three buttons together: only reset acts
    press(3'b111, NEED);
    step(6);

    // saturation while in lap, start_stop ignored, reset leaves
    press(3'b010, NEED);
    step(3);
    press(3'b100, NEED);
    step(2);
    max_reached = 1'b1;
    step(8);
    press(3'b010, NEED);
    step(4);
    press(3'b001, NEED);
    step(4);
    max_reached = 1'b0;

`ifdef DEBOUNCE_EN
    // too-short press must not start the watch
    press(3'b010, 2);
    step(10);
`endif

    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        step(DLY + 1);
        do_reset($urandom_range(1, 2));
      end else if (r < 20) begin
        max_reached = ($urandom_range(0, 3) == 0);
      end else begin
        if ($urandom_range(0, 9) == 0) msk = 3'($urandom_range(1, 7));
        else msk = 3'(1 << $urandom_range(0, 2));
        press(msk, NEED + $urandom_range(0, 2));
      end
      step($urandom_range(0, 10));
    end

    step(DLY + 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
